// File: rtl/i2cmb_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2cmb_seq_pkg
// Shared definitions for the IICMB Wishbone byte-transfer sequencer:
//   - IICMB register map (CSR/DPR/CMDR) and CMDR command codes
//   - CMDR status bit positions and response error codes
//   - sequencer FSM state enum
//   - seq_op(): maps a sequence step to the Wishbone access it performs
// ---------------------------------------------------------------------------
package i2cmb_seq_pkg;

  // IICMB register addresses
  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  // CMDR command codes (CMDR[2:0])
  localparam logic [2:0] CMD_WRITE    = 3'b001;
  localparam logic [2:0] CMD_READ_NAK = 3'b011;
  localparam logic [2:0] CMD_START    = 3'b100;
  localparam logic [2:0] CMD_STOP     = 3'b101;
  localparam logic [2:0] CMD_SET_BUS  = 3'b110;

  // CMDR status bit positions
  localparam int STAT_DON = 7;
  localparam int STAT_NAK = 6;
  localparam int STAT_AL  = 5;
  localparam int STAT_ERR = 4;

  // Response error codes
  localparam logic [1:0] RSP_OK       = 2'd0;
  localparam logic [1:0] RSP_NAK      = 2'd1;
  localparam logic [1:0] RSP_ARB_LOST = 2'd2;
  localparam logic [1:0] RSP_CORE_ERR = 2'd3;

  // CSR init values: core enable, optionally with interrupt enable
  localparam logic [7:0] CSR_INIT_POLL = 8'h80;
  localparam logic [7:0] CSR_INIT_IRQ  = 8'hC0;

  // Final step of every transfer is the STOP command
  localparam logic [2:0] STEP_STOP = 3'd7;

  typedef enum logic [2:0] {
    RESET_INIT,
    IDLE,
    WB_REQ,
    WAIT_DONE,
    RESPOND
  } seq_state_t;

  // One Wishbone access of the transfer sequence
  typedef struct packed {
    logic       we;
    logic [1:0] reg_sel;
    logic [7:0] data;
    logic       wait_done;  // CMDR write: poll completion afterwards
  } wb_op_t;

  // Step table. Write: bus, SET_BUS, START, addr, WRITE, wdata, WRITE, STOP.
  // Read : bus, SET_BUS, START, addr, WRITE, READ_NAK, read DPR, STOP.
  function automatic wb_op_t seq_op(input logic [2:0] step,
                                    input logic       rw,
                                    input logic [3:0] bus,
                                    input logic [7:0] addr_byte,
                                    input logic [7:0] wdata);
    wb_op_t op;
    op = '{we: 1'b1, reg_sel: REG_CMDR, data: 8'h00, wait_done: 1'b1};
    case (step)
      3'd0: begin op.reg_sel = REG_DPR; op.data = {4'h0, bus}; op.wait_done = 1'b0; end
      3'd1: op.data = {5'b0, CMD_SET_BUS};
      3'd2: op.data = {5'b0, CMD_START};
      3'd3: begin op.reg_sel = REG_DPR; op.data = addr_byte; op.wait_done = 1'b0; end
      3'd4: op.data = {5'b0, CMD_WRITE};
      3'd5: begin
        if (rw) op.data = {5'b0, CMD_READ_NAK};
        else begin op.reg_sel = REG_DPR; op.data = wdata; op.wait_done = 1'b0; end
      end
      3'd6: begin
        if (rw) begin op.we = 1'b0; op.reg_sel = REG_DPR; op.wait_done = 1'b0; end
        else op.data = {5'b0, CMD_WRITE};
      end
      default: op.data = {5'b0, CMD_STOP};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/i2cmb_wb_port.sv
// ---------------------------------------------------------------------------
// i2cmb_wb_port
// Single-access Wishbone master engine. A one-cycle start launches one
// access; cyc/stb/we/adr/dat are held until ack_i and dropped the next
// cycle, with done pulsing in that cycle. Read data is captured on the ack
// cycle. start is ignored while an access is in flight, and ack_i is
// ignored outside an access.
// Ports:
//   clk, rst                     clock, async active-high reset
//   start, we, adr, wdata        access request
//   done, rdata                  completion pulse, captured read data
//   cyc_o..dat_o, dat_i, ack_i   Wishbone master side
// ---------------------------------------------------------------------------
module i2cmb_wb_port #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     we,
  input  logic [WB_ADDR_WIDTH-1:0] adr,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  output logic                     done,
  output logic [WB_DATA_WIDTH-1:0] rdata,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i
);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      if (cyc_o) begin
        if (ack_i) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          adr_o <= '0;
          dat_o <= '0;
          done  <= 1'b1;
          if (!we_o) rdata <= dat_i;
        end
      end else if (start) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= we;
        adr_o <= adr;
        dat_o <= wdata;
      end
    end
  end

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// ---------------------------------------------------------------------------
// i2cmb_wb_sequencer
// Turns single-byte I2C read/write requests into IICMB register command
// sequences over Wishbone, polls CMDR for completion and reports a response.
// Configuration macro: I2CMB_SEQ_IRQ_EN -- when defined, CSR is written with
// the interrupt enable set and completion is awaited on irq_i before a single
// CMDR read; otherwise CMDR is polled until any status bit [7:4] is set.
// Ports:
//   clk_i, rst_i                          clock, async active-high reset
//   req_valid_i/req_ready_o, req_rw_i,    request handshake and fields
//   req_addr_i, req_wdata_i, req_bus_i
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   one-cycle response
//   cyc_o, stb_o, we_o, adr_o, dat_o,     Wishbone master to the IICMB core
//   dat_i, ack_i, irq_i
// ---------------------------------------------------------------------------
module i2cmb_wb_sequencer
  import i2cmb_seq_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rw_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]                req_wdata_i,
  input  logic [3:0]                req_bus_i,
  output logic                      rsp_valid_o,
  output logic [7:0]                rsp_rdata_o,
  output logic [1:0]                rsp_err_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

`ifdef I2CMB_SEQ_IRQ_EN
  localparam logic [7:0] CSR_INIT = CSR_INIT_IRQ;
  localparam logic       USE_IRQ  = 1'b1;
`else
  localparam logic [7:0] CSR_INIT = CSR_INIT_POLL;
  localparam logic       USE_IRQ  = 1'b0;
`endif

  seq_state_t                state;
  logic                      pending;     // an access was launched and is not yet done
  logic                      port_start;
  logic                      port_we;
  logic [WB_ADDR_WIDTH-1:0]  port_adr;
  logic [WB_DATA_WIDTH-1:0]  port_wdata;
  logic                      port_done;
  logic [WB_DATA_WIDTH-1:0]  port_rdata;
  logic [2:0]                step;
  logic                      lat_rw;
  logic [I2C_ADDR_WIDTH-1:0] lat_addr;
  logic [7:0]                lat_wdata;
  logic [3:0]                lat_bus;
  logic [1:0]                err;
  logic [7:0]                rdata_lat;
  wb_op_t                    cur_op;
  logic [7:0]                status;
  logic                      status_go;

  // NOTE: combinational blocks assign every output unconditionally first, so
  // no path leaves a value held and no latch is inferred.
  always_comb begin
    cur_op    = seq_op(step, lat_rw, lat_bus, 8'({lat_addr, lat_rw}), lat_wdata);
    status    = port_rdata[7:0];
    // Polling build reads CMDR back-to-back; IRQ build waits for the interrupt.
    status_go = USE_IRQ ? irq_i : 1'b1;
  end

  i2cmb_wb_port #(
    .WB_ADDR_WIDTH (WB_ADDR_WIDTH),
    .WB_DATA_WIDTH (WB_DATA_WIDTH)
  ) u_port (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (port_start),
    .we    (port_we),
    .adr   (port_adr),
    .wdata (port_wdata),
    .done  (port_done),
    .rdata (port_rdata),
    .cyc_o (cyc_o),
    .stb_o (stb_o),
    .we_o  (we_o),
    .adr_o (adr_o),
    .dat_o (dat_o),
    .dat_i (dat_i),
    .ack_i (ack_i)
  );

  // NOTE: reset clears only control and output registers; the latched request
  // fields are also cleared here because they feed outputs via cur_op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RESET_INIT;
      pending     <= 1'b0;
      port_start  <= 1'b0;
      port_we     <= 1'b0;
      port_adr    <= '0;
      port_wdata  <= '0;
      step        <= '0;
      lat_rw      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_bus     <= '0;
      err         <= RSP_OK;
      rdata_lat   <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= RSP_OK;
    end else begin
      port_start  <= 1'b0;
      rsp_valid_o <= 1'b0;
      case (state)
        RESET_INIT: begin
          if (!pending) begin
            port_start <= 1'b1;
            port_we    <= 1'b1;
            port_adr   <= WB_ADDR_WIDTH'(REG_CSR);
            port_wdata <= WB_DATA_WIDTH'(CSR_INIT);
            pending    <= 1'b1;
          end else if (port_done) begin
            pending     <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            lat_rw      <= req_rw_i;
            lat_addr    <= req_addr_i;
            lat_wdata   <= req_wdata_i;
            lat_bus     <= req_bus_i;
            step        <= '0;
            err         <= RSP_OK;
            rdata_lat   <= '0;
            req_ready_o <= 1'b0;
            state       <= WB_REQ;
          end
        end

        WB_REQ: begin
          if (!pending) begin
            port_start <= 1'b1;
            port_we    <= cur_op.we;
            port_adr   <= WB_ADDR_WIDTH'(cur_op.reg_sel);
            port_wdata <= WB_DATA_WIDTH'(cur_op.data);
            pending    <= 1'b1;
          end else if (port_done) begin
            pending <= 1'b0;
            if (!cur_op.we) rdata_lat <= port_rdata[7:0];
            if (cur_op.wait_done) state <= WAIT_DONE;
            else                  step  <= step + 3'd1;
          end
        end

        WAIT_DONE: begin
          if (!pending) begin
            if (status_go) begin
              port_start <= 1'b1;
              port_we    <= 1'b0;
              port_adr   <= WB_ADDR_WIDTH'(REG_CMDR);
              port_wdata <= '0;
              pending    <= 1'b1;
            end
          end else if (port_done) begin
            pending <= 1'b0;
            if (status[STAT_AL]) begin
              // Bus was lost: the core no longer owns it, so no STOP.
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= RSP_ARB_LOST;
              rsp_rdata_o <= rdata_lat;
              state       <= RESPOND;
            end else if (status[STAT_ERR]) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= RSP_CORE_ERR;
              rsp_rdata_o <= rdata_lat;
              state       <= RESPOND;
            end else if (status[STAT_NAK] && step != STEP_STOP) begin
              // Release the bus before reporting the NAK.
              err   <= RSP_NAK;
              step  <= STEP_STOP;
              state <= WB_REQ;
            end else if (status[STAT_DON] || status[STAT_NAK]) begin
              if (step == STEP_STOP) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= err;
                rsp_rdata_o <= rdata_lat;
                state       <= RESPOND;
              end else begin
                step  <= step + 3'd1;
                state <= WB_REQ;
              end
            end
            // No status bit set: command still running, read CMDR again.
          end
        end

        RESPOND: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end

        default: state <= RESET_INIT;
      endcase
    end
  end

endmodule
